// File: rtl/pipe_reg_chain_pkg.sv
// Shared helpers for the pipe_reg_chain register pipeline.
// Holds the occupancy-width function and the parameter legality check.
package pipe_reg_chain_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit params_legal(input int w, input int d);
        return (w >= 1) && (d >= 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One register stage: a valid bit plus a data word that only
// updates when a valid word is actually moving in.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int RESET_DATA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ld,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    logic             valid_d;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ld) begin
            valid_d = src_valid;
        end
    end

    // Data is held on bubbles so the datapath does not toggle.
    always_comb begin
        data_d = data_q;
        if (flush && (RESET_DATA != 0)) begin
            data_d = '0;
        end else if (!flush && ld && src_valid) begin
            data_d = src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    if (RESET_DATA != 0) begin : g_data_rst
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end
    end else begin : g_data_norst
        always_ff @(posedge clk) begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int RESET_DATA = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [clog2(DEPTH+1)-1:0]      occupancy
);

    localparam int OW = clog2(DEPTH + 1);

    if (!params_legal(WIDTH, DEPTH)) begin : g_illegal
        $fatal(1, "pipe_reg_chain: WIDTH and DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] stg_valid;
    logic [WIDTH-1:0] stg_data [DEPTH];
    logic             rdy_run;
    logic             in_xfer;
    logic             out_xfer;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;

    // A stage may load if it is empty or everything after it moves.
    always_comb begin
        rdy     = '0;
        rdy_run = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_run = !stg_valid[k] | rdy_run;
            rdy[k]  = rdy_run;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             sv;
        logic [WIDTH-1:0] sd;

        if (k == 0) begin : g_head
            assign sv = in_valid;
            assign sd = in_data;
        end else begin : g_body
            assign sv = stg_valid[k-1];
            assign sd = stg_data[k-1];
        end

        pipe_stage #(
            .WIDTH      (WIDTH),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .ld        (rdy[k]),
            .src_valid (sv),
            .src_data  (sd),
            .valid_q   (stg_valid[k]),
            .data_q    (stg_data[k])
        );
    end

    assign in_ready  = rdy[0] & !flush;
    assign out_valid = stg_valid[DEPTH-1];
    assign out_data  = stg_data[DEPTH-1];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OW'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule
